// File: rtl/dmem_responder.sv
// dmem_responder: slave side of the CPU MEM-stage data bus.
// Samples a read/write request, stalls the pipeline for WAIT_CYCLES extra
// cycles, then completes the access against a word-addressed 16-bit RAM.
// Optional feature macro: DMEM_MMIO_EN (memory-mapped cycle counter and
// output port at 0xFFF0-0xFFFF).
//
// Handshake: the CPU presents mem_op/address/write_data and holds them while
// stall is high; the request is taken in the IDLE cycle it appears in, and
// ready pulses for exactly one cycle (stall low) when the access completes,
// with read_data valid in that same cycle.
module dmem_responder #(
    parameter int ADDR_BITS   = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] address,
    input  logic [15:0] write_data,
    input  logic [1:0]  mem_op,
    output logic        stall,
    output logic        ready,
    output logic [15:0] read_data,
    output logic [15:0] io_out,
    output logic        err,
    output logic [1:0]  fsm_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int DEPTH = 1 << ADDR_BITS;
    localparam logic [3:0] WLOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_t                 state;
    state_t                 next_state;
    logic [3:0]             wcnt;
    logic                   accept;
    logic                   commit;
    logic                   set_err;

    logic [ADDR_BITS-1:0]   lat_idx;
    logic [15:0]            lat_data;
    logic                   lat_write;

    // Effective access fields: live inputs when committing straight out of
    // IDLE (zero wait states), latched copies otherwise.
    logic [ADDR_BITS-1:0]   eff_idx;
    logic [15:0]            eff_data;
    logic                   eff_write;
    logic                   ram_hit;

    logic [15:0]            mem [0:DEPTH-1];

    // Only the low address bits reach the RAM index; the rest is decoded
    // (MMIO build) or deliberately ignored (wrap-around).
    logic                   unused_addr;
    assign unused_addr = ^address;

    assign fsm_state = state;
    assign ready     = (state == S_DONE);

    assign eff_idx   = (state == S_IDLE) ? address[ADDR_BITS-1:0] : lat_idx;
    assign eff_data  = (state == S_IDLE) ? write_data : lat_data;
    assign eff_write = (state == S_IDLE) ? (mem_op == 2'b10) : lat_write;

`ifdef DMEM_MMIO_EN
    logic        lat_mmio;
    logic [3:0]  lat_sel;
    logic        eff_mmio;
    logic [3:0]  eff_sel;
    logic [15:0] cycle_cnt;
    logic [15:0] mmio_rdata;

    assign eff_mmio = (state == S_IDLE) ? (address[15:4] == 12'hFFF) : lat_mmio;
    assign eff_sel  = (state == S_IDLE) ? address[3:0] : lat_sel;
    assign ram_hit  = !eff_mmio;

    // MMIO read mux: counter, output port, everything else reads zero.
    always_comb begin
        mmio_rdata = 16'h0000;
        case (eff_sel)
            4'h0:    mmio_rdata = cycle_cnt;
            4'h1:    mmio_rdata = io_out;
            default: mmio_rdata = 16'h0000;
        endcase
    end

    // Free-running cycle counter, wraps naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (reset) cycle_cnt <= 16'h0000;
        else       cycle_cnt <= cycle_cnt + 16'h0001;
    end

    // Output port register, written by a committed store to 0xFFF1.
    always_ff @(posedge clk) begin
        if (reset)
            io_out <= 16'h0000;
        else if (commit && eff_write && eff_mmio && eff_sel == 4'h1)
            io_out <= eff_data;
    end

    // MMIO decode fields captured with the request.
    always_ff @(posedge clk) begin
        if (reset) begin
            lat_mmio <= 1'b0;
            lat_sel  <= 4'h0;
        end else if (accept) begin
            lat_mmio <= (address[15:4] == 12'hFFF);
            lat_sel  <= address[3:0];
        end
    end
`else
    assign ram_hit = 1'b1;
    assign io_out  = 16'h0000;
`endif

    // Next-state, stall and commit decode; reset overrides everything.
    always_comb begin
        next_state = state;
        stall      = 1'b0;
        accept     = 1'b0;
        set_err    = 1'b0;
        case (state)
            S_IDLE: begin
                if (mem_op == 2'b01 || mem_op == 2'b10) begin
                    stall      = 1'b1;
                    accept     = 1'b1;
                    next_state = (WAIT_CYCLES > 0) ? S_WAIT : S_DONE;
                end else if (mem_op == 2'b11) begin
                    set_err = 1'b1;
                end
            end
            S_WAIT: begin
                stall = 1'b1;
                if (wcnt == 4'd0) next_state = S_DONE;
            end
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
        if (reset) begin
            next_state = S_IDLE;
            stall      = 1'b0;
            accept     = 1'b0;
            set_err    = 1'b0;
        end
        commit = (next_state == S_DONE) && (state != S_DONE);
    end

    // State register and wait-state counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            wcnt  <= 4'd0;
        end else begin
            state <= next_state;
            if (accept)
                wcnt <= WLOAD;
            else if (state == S_WAIT && wcnt != 4'd0)
                wcnt <= wcnt - 4'd1;
        end
    end

    // Request capture so the CPU's inputs may change after acceptance.
    always_ff @(posedge clk) begin
        if (reset) begin
            lat_idx   <= '0;
            lat_data  <= 16'h0000;
            lat_write <= 1'b0;
        end else if (accept) begin
            lat_idx   <= address[ADDR_BITS-1:0];
            lat_data  <= write_data;
            lat_write <= (mem_op == 2'b10);
        end
    end

    // Sticky error for a reserved mem_op seen in IDLE.
    always_ff @(posedge clk) begin
        if (reset)        err <= 1'b0;
        else if (set_err) err <= 1'b1;
    end

    // RAM write port; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (commit && eff_write && ram_hit)
            mem[eff_idx] <= eff_data;
    end

    // Registered load data, updated only when a read commits.
    always_ff @(posedge clk) begin
        if (reset)
            read_data <= 16'h0000;
        else if (commit && !eff_write) begin
`ifdef DMEM_MMIO_EN
            read_data <= eff_mmio ? mmio_rdata : mem[eff_idx];
`else
            read_data <= mem[eff_idx];
`endif
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed testbench for dmem_responder: one instance with two wait states,
// one with zero wait states, sharing clock, reset and address/data buses.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] address;
    logic [15:0] write_data;
    logic [1:0]  mem_op_a;
    logic [1:0]  mem_op_b;

    logic        stall_a, ready_a, err_a;
    logic [15:0] read_data_a, io_out_a;
    logic [1:0]  fsm_state_a;
    logic        stall_b, ready_b, err_b;
    logic [15:0] read_data_b, io_out_b;
    logic [1:0]  fsm_state_b;

    int n_cmp = 0;
    int n_bad = 0;

    // Clock: 10 ns period.
    always #5 clk = ~clk;

    dmem_responder #(.ADDR_BITS(8), .WAIT_CYCLES(2)) dut_a (
        .clk(clk), .reset(reset), .address(address), .write_data(write_data),
        .mem_op(mem_op_a), .stall(stall_a), .ready(ready_a),
        .read_data(read_data_a), .io_out(io_out_a), .err(err_a),
        .fsm_state(fsm_state_a)
    );

    dmem_responder #(.ADDR_BITS(8), .WAIT_CYCLES(0)) dut_b (
        .clk(clk), .reset(reset), .address(address), .write_data(write_data),
        .mem_op(mem_op_b), .stall(stall_b), .ready(ready_b),
        .read_data(read_data_b), .io_out(io_out_b), .err(err_b),
        .fsm_state(fsm_state_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drives one access starting just after a rising edge with the DUT in IDLE.
    // Holds the request until ready, counts stall cycles, records the ready
    // cycle index (relative to the request cycle) and the data seen with it.
    task automatic run_acc(input bit on_b, input logic [1:0] op, input logic [15:0] addr,
                           input logic [15:0] wd, output int n_stall, output int rdy_at,
                           output logic [15:0] rd);
        n_stall = 0;
        rdy_at  = -1;
        rd      = 16'h0000;
        address    = addr;
        write_data = wd;
        if (on_b) mem_op_b = op; else mem_op_a = op;
        for (int c = 0; c < 20 && rdy_at < 0; c++) begin
            @(negedge clk);
            if (on_b ? stall_b : stall_a) n_stall++;
            if (on_b ? ready_b : ready_a) begin
                rdy_at = c;
                rd     = on_b ? read_data_b : read_data_a;
            end
            @(posedge clk); #1;
        end
        mem_op_a = 2'b00;
        mem_op_b = 2'b00;
    endtask

    // One access plus timing checks; read data is checked when chk_rd is set.
    task automatic xfer(input string tag, input bit on_b, input logic [1:0] op,
                        input logic [15:0] addr, input logic [15:0] wd,
                        input bit chk_rd, input logic [15:0] exp_rd);
        int n_stall, rdy_at, exp_wait;
        logic [15:0] rd;
        exp_wait = on_b ? 0 : 2;
        run_acc(on_b, op, addr, wd, n_stall, rdy_at, rd);
        check({tag, "_stall_cycles"}, 32'(n_stall), 32'(exp_wait + 1));
        check({tag, "_ready_cycle"}, 32'(rdy_at), 32'(exp_wait + 1));
        if (chk_rd) check({tag, "_read_data"}, {16'h0, rd}, {16'h0, exp_rd});
    endtask

    initial begin
        reset      = 1'b1;
        address    = 16'h0000;
        write_data = 16'h0000;
        mem_op_a   = 2'b01;      // a request during reset must not stall
        mem_op_b   = 2'b10;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_stall_a", {31'h0, stall_a}, 32'h0);
        check("rst_stall_b", {31'h0, stall_b}, 32'h0);
        check("rst_ready_a", {31'h0, ready_a}, 32'h0);
        check("rst_read_data_a", {16'h0, read_data_a}, 32'h0);
        check("rst_err_a", {31'h0, err_a}, 32'h0);
        check("rst_io_out_a", {16'h0, io_out_a}, 32'h0);
        check("rst_state_a", {30'h0, fsm_state_a}, 32'h0);
        mem_op_a = 2'b00;
        mem_op_b = 2'b00;
        @(posedge clk); #1;
        reset = 1'b0;

        // Two wait states: write then back-to-back read.
        xfer("init9", 1'b0, 2'b10, 16'h0009, 16'h0000, 1'b0, 16'h0000);
        xfer("wr5", 1'b0, 2'b10, 16'h0005, 16'hBEEF, 1'b0, 16'h0000);
        check("wr_keeps_read_data", {16'h0, read_data_a}, 32'h0);
        xfer("rd5", 1'b0, 2'b01, 16'h0005, 16'h0000, 1'b1, 16'hBEEF);

        // Address wrap modulo 256 words.
        xfer("wr107", 1'b0, 2'b10, 16'h0107, 16'h00AA, 1'b0, 16'h0000);
        xfer("rd007", 1'b0, 2'b01, 16'h0007, 16'h0000, 1'b1, 16'h00AA);
        xfer("rd207", 1'b0, 2'b01, 16'h0207, 16'h0000, 1'b1, 16'h00AA);
        check("rd_data_holds", {16'h0, read_data_a}, 32'h00AA);

        // Zero wait states.
        xfer("b_wr3", 1'b1, 2'b10, 16'h0003, 16'h1234, 1'b0, 16'h0000);
        xfer("b_rd3", 1'b1, 2'b01, 16'h0003, 16'h0000, 1'b1, 16'h1234);

        // Reserved op: sets err, never stalls, leaves RAM alone.
        address    = 16'h0005;
        write_data = 16'hDEAD;
        mem_op_a   = 2'b11;
        @(negedge clk);
        check("rsv_stall", {31'h0, stall_a}, 32'h0);
        @(posedge clk); #1;
        mem_op_a = 2'b00;
        check("rsv_err", {31'h0, err_a}, 32'h1);
        check("rsv_state", {30'h0, fsm_state_a}, 32'h0);
        xfer("rsv_rd5", 1'b0, 2'b01, 16'h0005, 16'h0000, 1'b1, 16'hBEEF);
        check("err_sticky", {31'h0, err_a}, 32'h1);

        // Reset during WAIT drops the uncommitted write.
        address    = 16'h0009;
        write_data = 16'h5555;
        mem_op_a   = 2'b10;
        @(posedge clk); #1;
        check("mid_state_wait", {30'h0, fsm_state_a}, 32'h1);
        reset    = 1'b1;
        mem_op_a = 2'b00;
        @(negedge clk);
        check("mid_stall_in_reset", {31'h0, stall_a}, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        check("mid_state_idle", {30'h0, fsm_state_a}, 32'h0);
        check("mid_err_cleared", {31'h0, err_a}, 32'h0);
        @(negedge clk);
        check("mid_stall_after", {31'h0, stall_a}, 32'h0);
        check("mid_ready_after", {31'h0, ready_a}, 32'h0);
        @(posedge clk); #1;
        xfer("mid_rd9", 1'b0, 2'b01, 16'h0009, 16'h0000, 1'b1, 16'h0000);
        xfer("mid_rd5", 1'b0, 2'b01, 16'h0005, 16'h0000, 1'b1, 16'hBEEF);

`ifdef DMEM_MMIO_EN
        begin
            int n_stall, rdy_at;
            logic [15:0] v1, v2;
            xfer("ram_f1_wr", 1'b0, 2'b10, 16'h00F1, 16'h1111, 1'b0, 16'h0000);
            xfer("io_wr", 1'b0, 2'b10, 16'hFFF1, 16'h00F0, 1'b0, 16'h0000);
            check("io_out", {16'h0, io_out_a}, 32'h00F0);
            xfer("io_rd", 1'b0, 2'b01, 16'hFFF1, 16'h0000, 1'b1, 16'h00F0);
            xfer("ram_f1_rd", 1'b0, 2'b01, 16'h00F1, 16'h0000, 1'b1, 16'h1111);
            xfer("mmio_other_rd", 1'b0, 2'b01, 16'hFFF7, 16'h0000, 1'b1, 16'h0000);
            // Issue distance: 4 cycles of occupancy plus 7 idle cycles.
            run_acc(1'b0, 2'b01, 16'hFFF0, 16'h0000, n_stall, rdy_at, v1);
            repeat (7) @(posedge clk);
            #1;
            run_acc(1'b0, 2'b01, 16'hFFF0, 16'h0000, n_stall, rdy_at, v2);
            check("cnt_delta", {16'h0, v2 - v1}, 32'd11);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
